// File: rtl/ram_pixel_streamer.sv
// Raster-order reader for the image RAM: streams IMG_H x IMG_W pixels over valid/ready with sof/eol/eof.
// Optional FRAME_CHECKSUM_EN adds a per-frame sum of accepted pixels on port checksum.
module ram_pixel_streamer #(
  parameter int N        = 10,
  parameter int M        = 8,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int BASE_ADR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout,
  output logic [M-1:0] pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_sof,
  output logic         pix_eol,
`ifdef FRAME_CHECKSUM_EN
  output logic [M+N-1:0] checksum,
`endif
  output logic         pix_eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [N-1:0]  ADR0     = N'(BASE_ADR);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          load;
  logic          accept;
  logic          last_col;
  logic          last_row;

  assign ram_we  = 1'b0;
  assign ram_din = '0;

  assign accept   = pix_valid & pix_ready;
  assign load     = (state == STREAM) && (!pix_valid || pix_ready);
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // row/col and ram_adr always describe the next pixel to be loaded; the
  // address advances by increment so it tracks BASE_ADR + row*IMG_W + col.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      ram_adr   <= ADR0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            busy    <= 1'b1;
            row     <= '0;
            col     <= '0;
            ram_adr <= ADR0;
          end
        end
        STREAM: begin
          if (load) begin
            pix_data  <= ram_dout;
            pix_valid <= 1'b1;
            pix_sof   <= (row == '0) && (col == '0);
            pix_eol   <= last_col;
            pix_eof   <= last_col && last_row;
            ram_adr   <= ram_adr + 1'b1;
            if (last_col) begin
              col <= '0;
              row <= last_row ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_col && last_row)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Cleared when a frame is accepted, then holds its final value after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + (M+N)'(pix_data);
    end
  end
`endif

endmodule
